// File: rtl/ldtu_pkg.sv
// ---------------------------------------------------------------------------
// ldtu_pkg
// Shared constants for the LDTU gain-selection slice.
//   Nbits_12       : width of one baseline-subtracted sample
//   LOOKAHEAD_DEF  : default look-ahead depth (pre-saturation samples)
//   CNT_W          : window counter width; 2**CNT_W must exceed LOOKAHEAD+15
//   GAIN_FLAG_G1   : flag value marking a gain_1 sample
//   OUT_W, FLAG_BIT, DATA_MSB, DATA_LSB : layout of the 13-bit encoder word
// ---------------------------------------------------------------------------
package ldtu_pkg;
   localparam int Nbits_12      = 12;
   localparam int LOOKAHEAD_DEF = 8;
   localparam int CNT_W         = 5;
   localparam logic GAIN_FLAG_G1 = 1'b1;

   localparam int OUT_W    = Nbits_12 + 1;
   localparam int FLAG_BIT = Nbits_12;
   localparam int DATA_MSB = Nbits_12 - 1;
   localparam int DATA_LSB = 0;
endpackage

// File: rtl/ldtu_delay_line.sv
// ---------------------------------------------------------------------------
// ldtu_delay_line
// WIDTH x DEPTH shift register advancing every clock; tap is the sample that
// entered DEPTH cycles earlier. All stages clear synchronously on rst_b low.
// Ports:
//   DCLK_1  in   clock
//   rst_b   in   synchronous active-low clear
//   din     in   WIDTH  new sample
//   tap     out  WIDTH  oldest stage
// ---------------------------------------------------------------------------
module ldtu_delay_line #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 8
) (
   input  logic             DCLK_1,
   input  logic             rst_b,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] tap
);

   logic [WIDTH-1:0] stage_reg [DEPTH];

   always_ff @(posedge DCLK_1) begin
      if (!rst_b) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_reg[i] <= '0;
         end
      end else begin
         stage_reg[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign tap = stage_reg[DEPTH-1];

endmodule

// File: rtl/ldtu_gain_selection.sv
// ---------------------------------------------------------------------------
// ldtu_gain_selection
// Merges the gain_1 and gain_10 streams into one 13-bit encoder stream.
// gain_10 is used by default; a saturating gain_10 input sample switches the
// output to gain_1 from LOOKAHEAD samples before the hit until time_window
// samples after it. Both streams pass through LOOKAHEAD-deep delay lines so
// the switch can reach back before the hit.
// Ports:
//   DCLK_1            in   clock
//   rst_b             in   synchronous active-low reset
//   DATA_gain_01      in   12  gain_1 sample
//   DATA_gain_10      in   12  gain_10 sample
//   SATURATION_value  in   12  gain_10 saturation threshold (unsigned >=)
//   time_window       in   4   post-saturation samples kept on gain_1
//   forceG1           in   1   force gain_1 (priority over forceG10)
//   forceG10          in   1   force gain_10
//   DATA_to_enc       out  13  {gain_flag, sample}, gain_flag 1 = gain_1
//   sat_window        out  1   registered auto-selection (ignores force)
//   SeuError          out  1   constant 0
// LOOKAHEAD must lie in 1..15 and satisfy 2**CNT_W > LOOKAHEAD+15.
// ---------------------------------------------------------------------------
module ldtu_gain_selection
   import ldtu_pkg::*;
#(
   parameter int LOOKAHEAD = LOOKAHEAD_DEF
) (
   input  logic                DCLK_1,
   input  logic                rst_b,
   input  logic [Nbits_12-1:0] DATA_gain_01,
   input  logic [Nbits_12-1:0] DATA_gain_10,
   input  logic [Nbits_12-1:0] SATURATION_value,
   input  logic [3:0]          time_window,
   input  logic                forceG1,
   input  logic                forceG10,
   output logic [OUT_W-1:0]    DATA_to_enc,
   output logic                sat_window,
   output logic                SeuError
);

   logic [Nbits_12-1:0] tap_g01;
   logic [Nbits_12-1:0] tap_g10;
   logic [CNT_W-1:0]    cnt_reg;
   logic [CNT_W-1:0]    cnt_next;
   logic                sat_now;
   logic                sel_g1;
   logic                final_sel;
   logic [Nbits_12-1:0] final_data;

   ldtu_delay_line #(.WIDTH(Nbits_12), .DEPTH(LOOKAHEAD)) u_dly_g01 (
      .DCLK_1 (DCLK_1),
      .rst_b  (rst_b),
      .din    (DATA_gain_01),
      .tap    (tap_g01)
   );

   ldtu_delay_line #(.WIDTH(Nbits_12), .DEPTH(LOOKAHEAD)) u_dly_g10 (
      .DCLK_1 (DCLK_1),
      .rst_b  (rst_b),
      .din    (DATA_gain_10),
      .tap    (tap_g10)
   );

   // Detection looks at the undelayed sample, so the current hit selects
   // the tap that entered LOOKAHEAD cycles ago: that is the reach-back.
   assign sat_now = (DATA_gain_10 >= SATURATION_value);

   // Counter covers the remaining LOOKAHEAD+time_window taps after the hit;
   // any new hit reloads it so overlapping windows merge.
   always_comb begin
      cnt_next = cnt_reg;
      if (sat_now) begin
         cnt_next = CNT_W'(LOOKAHEAD) + CNT_W'(time_window);
      end else if (cnt_reg != '0) begin
         cnt_next = cnt_reg - 1'b1;
      end
   end

   assign sel_g1 = sat_now | (cnt_reg != '0);

   always_comb begin
      final_sel = sel_g1;
      if (forceG1) begin
         final_sel = GAIN_FLAG_G1;
      end else if (forceG10) begin
         final_sel = ~GAIN_FLAG_G1;
      end
      final_data = (final_sel == GAIN_FLAG_G1) ? tap_g01 : tap_g10;
   end

   always_ff @(posedge DCLK_1) begin
      if (!rst_b) begin
         cnt_reg     <= '0;
         DATA_to_enc <= '0;
         sat_window  <= 1'b0;
      end else begin
         cnt_reg                        <= cnt_next;
         DATA_to_enc[FLAG_BIT]          <= final_sel;
         DATA_to_enc[DATA_MSB:DATA_LSB] <= final_data;
         sat_window                     <= sel_g1;
      end
   end

   assign SeuError = 1'b0;

endmodule
